// File: rtl/rx_pid_tracker.sv
// Receive PID decoder with per-endpoint DATA0/DATA1 toggle tracking and error counter.
// Latency: one cycle; store_pid sampled at edge N, all outputs registered and updated at edge N.
// Backpressure: none; accepts one PID per cycle, no ready signal.
module rx_pid_tracker #(
  parameter int NUM_EP   = 4,
  parameter int EP_W     = 2,
  parameter int EXT_PIDS = 0,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              store_pid,
  input  logic [7:0]        p_out,
  input  logic [EP_W-1:0]   ep_sel,
  input  logic              clr_toggle,
  input  logic [EP_W-1:0]   clr_ep,
  input  logic              clr_count,
  output logic [3:0]        rx_packet,
  output logic              pid_valid,
  output logic              pid_err,
  output logic              data_ok,
  output logic              seq_err,
  output logic [NUM_EP-1:0] exp_toggle,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  logic [3:0]        code;
  logic              check_ok;
  logic              base_pid;
  logic              accept;
  logic              reject;
  logic              is_data;
  logic              is_setup;
  logic              sel_hit;
  logic              cur_tog;
  logic              tog_match;
  logic              tog_miss;
  logic [NUM_EP-1:0] tog_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Decode the captured byte, look up the addressed endpoint and form next state.
  always_comb begin
    code     = p_out[3:0];
    check_ok = (p_out[7:4] == ~p_out[3:0]);
    base_pid = 1'b0;
    case (code)
      PID_OUT, PID_IN, PID_DATA0, PID_DATA1,
      PID_ACK, PID_NAK, PID_STALL: base_pid = 1'b1;
      default:                     base_pid = 1'b0;
    endcase
    accept   = store_pid && check_ok && ((EXT_PIDS != 0) || base_pid);
    reject   = store_pid && !accept;
    is_data  = (code == PID_DATA0) || (code == PID_DATA1);
    // SETUP can only be accepted when extended PIDs are enabled.
    is_setup = (code == PID_SETUP);

    // Only endpoints that exist can hit; out-of-range ep_sel leaves the table alone.
    sel_hit = 1'b0;
    cur_tog = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep_sel == EP_W'(i)) begin
        sel_hit = 1'b1;
        cur_tog = exp_toggle[i];
      end
    end

    // Toggle check uses the pre-clear table value.
    tog_match = accept && is_data && sel_hit && (code[3] == cur_tog);
    tog_miss  = accept && is_data && sel_hit && (code[3] != cur_tog);

    // Clear is applied last so it wins over a same-endpoint DATA/SETUP update.
    tog_nxt = exp_toggle;
    for (int i = 0; i < NUM_EP; i++) begin
      if (accept && (ep_sel == EP_W'(i))) begin
        if (tog_match) tog_nxt[i] = ~exp_toggle[i];
        if (is_setup)  tog_nxt[i] = 1'b0;
      end
      if (clr_toggle && (clr_ep == EP_W'(i))) tog_nxt[i] = 1'b0;
    end

    cnt_nxt = err_count;
    if (clr_count) begin
      cnt_nxt = '0;
    end else if ((reject || tog_miss) && (err_count != {CNT_W{1'b1}})) begin
      cnt_nxt = err_count + CNT_W'(1);
    end
  end

  // Register all outputs; pulses are only high in the cycle after a store_pid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_packet  <= 4'b0000;
      pid_valid  <= 1'b0;
      pid_err    <= 1'b0;
      data_ok    <= 1'b0;
      seq_err    <= 1'b0;
      exp_toggle <= '0;
      err_count  <= '0;
    end else begin
      if (accept) rx_packet <= code;
      pid_valid  <= accept;
      pid_err    <= reject;
      data_ok    <= tog_match;
      seq_err    <= tog_miss;
      exp_toggle <= tog_nxt;
      err_count  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rx_pid_tracker.sv
// Directed bench for rx_pid_tracker: two instances (base PID set with 2-bit counter,
// extended PID set with 3 endpoints), table-driven vectors plus an async reset sequence.
module tb_rx_pid_tracker;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       store_pid;
  logic [7:0] p_out;
  logic [1:0] ep_sel;
  logic       clr_toggle;
  logic [1:0] clr_ep;
  logic       clr_count;

  logic [3:0] rx0, rx1;
  logic       pv0, pe0, dk0, se0, pv1, pe1, dk1, se1;
  logic [3:0] tg0;
  logic [2:0] tg1;
  logic [1:0] cn0;
  logic [7:0] cn1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_pid_tracker #(.NUM_EP(4), .EP_W(2), .EXT_PIDS(0), .CNT_W(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .store_pid(store_pid), .p_out(p_out), .ep_sel(ep_sel),
    .clr_toggle(clr_toggle), .clr_ep(clr_ep), .clr_count(clr_count),
    .rx_packet(rx0), .pid_valid(pv0), .pid_err(pe0), .data_ok(dk0), .seq_err(se0),
    .exp_toggle(tg0), .err_count(cn0)
  );

  rx_pid_tracker #(.NUM_EP(3), .EP_W(2), .EXT_PIDS(1), .CNT_W(8)) dut1 (
    .clk(clk), .n_rst(n_rst), .store_pid(store_pid), .p_out(p_out), .ep_sel(ep_sel),
    .clr_toggle(clr_toggle), .clr_ep(clr_ep), .clr_count(clr_count),
    .rx_packet(rx1), .pid_valid(pv1), .pid_err(pe1), .data_ok(dk1), .seq_err(se1),
    .exp_toggle(tg1), .err_count(cn1)
  );

  typedef struct {
    logic       st;
    logic [7:0] pb;
    logic [1:0] ep;
    logic       ct;
    logic [1:0] ce;
    logic       cc;
    logic [3:0] rx;
    logic       pv, pe, dk, se;
    logic [3:0] tg;
    logic [7:0] cn;
  } vec_t;

  vec_t tab0[$];
  vec_t tab1[$];

  function automatic vec_t mk(input logic st, input logic [7:0] pb, input logic [1:0] ep,
                              input logic ct, input logic [1:0] ce, input logic cc,
                              input logic [3:0] rx, input logic pv, input logic pe,
                              input logic dk, input logic se, input logic [3:0] tg,
                              input logic [7:0] cn);
    vec_t v;
    v.st = st; v.pb = pb; v.ep = ep; v.ct = ct; v.ce = ce; v.cc = cc;
    v.rx = rx; v.pv = pv; v.pe = pe; v.dk = dk; v.se = se; v.tg = tg; v.cn = cn;
    return v;
  endfunction

  function automatic logic [19:0] obs(input int which);
    if (which == 0) return {rx0, pv0, pe0, dk0, se0, tg0, 6'b0, cn0};
    else            return {rx1, pv1, pe1, dk1, se1, 1'b0, tg1, cn1};
  endfunction

  task automatic check(input string name, input int idx, input logic [19:0] act,
                       input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got rx=%h pv/pe/ok/se=%b tog=%b cnt=%0d, want rx=%h pv/pe/ok/se=%b tog=%b cnt=%0d",
               name, idx, act[19:16], act[15:12], act[11:8], act[7:0],
               exp[19:16], exp[15:12], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic idle_inputs();
    store_pid = 0; p_out = 8'h00; ep_sel = 0; clr_toggle = 0; clr_ep = 0; clr_count = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    n_rst = 0;
    #1;
    check("reset0", 0, obs(0), 20'h0);
    check("reset1", 0, obs(1), 20'h0);
    @(negedge clk);
    n_rst = 1;
  endtask

  task automatic run_tab(input int which, input vec_t v, input int idx);
    store_pid = v.st; p_out = v.pb; ep_sel = v.ep;
    clr_toggle = v.ct; clr_ep = v.ce; clr_count = v.cc;
    @(posedge clk);
    #1;
    check(which == 0 ? "base" : "ext", idx, obs(which),
          {v.rx, v.pv, v.pe, v.dk, v.se, v.tg, v.cn});
    idle_inputs();
  endtask

  initial begin
    n_rst = 0;
    idle_inputs();

    //         st pb     ep ct ce cc  rx    pv pe ok se tog      cnt
    tab0.push_back(mk(1, 8'hE1, 0, 0, 0, 0, 4'h1, 1, 0, 0, 0, 4'b0000, 0));
    tab0.push_back(mk(1, 8'h69, 0, 0, 0, 0, 4'h9, 1, 0, 0, 0, 4'b0000, 0));
    tab0.push_back(mk(1, 8'hD2, 0, 0, 0, 0, 4'h2, 1, 0, 0, 0, 4'b0000, 0));
    tab0.push_back(mk(1, 8'hE1, 0, 0, 0, 0, 4'h1, 1, 0, 0, 0, 4'b0000, 0));
    tab0.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 4'h1, 0, 1, 0, 0, 4'b0000, 1));
    tab0.push_back(mk(1, 8'h2D, 0, 0, 0, 0, 4'h1, 0, 1, 0, 0, 4'b0000, 2));
    tab0.push_back(mk(0, 8'hE0, 0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 4'b0000, 2));
    tab0.push_back(mk(1, 8'hC3, 2, 0, 0, 0, 4'h3, 1, 0, 1, 0, 4'b0100, 2));
    tab0.push_back(mk(1, 8'hC3, 2, 0, 0, 0, 4'h3, 1, 0, 0, 1, 4'b0100, 3));
    tab0.push_back(mk(1, 8'h4B, 2, 0, 0, 0, 4'hB, 1, 0, 1, 0, 4'b0000, 3));
    tab0.push_back(mk(1, 8'hC3, 1, 0, 0, 0, 4'h3, 1, 0, 1, 0, 4'b0010, 3));
    tab0.push_back(mk(1, 8'h4B, 1, 1, 1, 0, 4'hB, 1, 0, 1, 0, 4'b0000, 3));
    tab0.push_back(mk(1, 8'hC3, 1, 0, 0, 0, 4'h3, 1, 0, 1, 0, 4'b0010, 3));
    tab0.push_back(mk(1, 8'hC3, 0, 1, 1, 0, 4'h3, 1, 0, 1, 0, 4'b0001, 3));
    tab0.push_back(mk(0, 8'h00, 0, 0, 0, 1, 4'h3, 0, 0, 0, 0, 4'b0001, 0));
    tab0.push_back(mk(1, 8'hE0, 0, 0, 0, 1, 4'h3, 0, 1, 0, 0, 4'b0001, 0));
    tab0.push_back(mk(1, 8'h00, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0001, 1));
    tab0.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0001, 2));
    tab0.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0001, 3));
    tab0.push_back(mk(1, 8'h2D, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0001, 3));
    tab0.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0001, 3));
    tab0.push_back(mk(1, 8'h1E, 0, 0, 0, 0, 4'hE, 1, 0, 0, 0, 4'b0001, 3));
    tab0.push_back(mk(1, 8'h5A, 0, 0, 0, 0, 4'hA, 1, 0, 0, 0, 4'b0001, 3));
    tab0.push_back(mk(1, 8'h87, 0, 0, 0, 0, 4'hA, 0, 1, 0, 0, 4'b0001, 3));
    tab0.push_back(mk(0, 8'h00, 0, 0, 0, 1, 4'hA, 0, 0, 0, 0, 4'b0001, 0));

    tab1.push_back(mk(1, 8'hC3, 0, 0, 0, 0, 4'h3, 1, 0, 1, 0, 4'b0001, 0));
    tab1.push_back(mk(1, 8'h2D, 0, 0, 0, 0, 4'hD, 1, 0, 0, 0, 4'b0000, 0));
    tab1.push_back(mk(1, 8'hC3, 1, 0, 0, 0, 4'h3, 1, 0, 1, 0, 4'b0010, 0));
    tab1.push_back(mk(1, 8'h87, 1, 0, 0, 0, 4'h7, 1, 0, 0, 0, 4'b0010, 0));
    tab1.push_back(mk(1, 8'h0F, 1, 0, 0, 0, 4'hF, 1, 0, 0, 0, 4'b0010, 0));
    tab1.push_back(mk(1, 8'hC3, 3, 0, 0, 0, 4'h3, 1, 0, 0, 0, 4'b0010, 0));
    tab1.push_back(mk(0, 8'h00, 0, 1, 3, 0, 4'h3, 0, 0, 0, 0, 4'b0010, 0));
    tab1.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0010, 1));
    tab1.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 4'h5, 1, 0, 0, 0, 4'b0010, 1));
    tab1.push_back(mk(1, 8'h3C, 0, 0, 0, 0, 4'hC, 1, 0, 0, 0, 4'b0010, 1));
    tab1.push_back(mk(1, 8'hC3, 1, 0, 0, 0, 4'h3, 1, 0, 0, 1, 4'b0010, 2));
    tab1.push_back(mk(1, 8'h2D, 1, 0, 0, 0, 4'hD, 1, 0, 0, 0, 4'b0000, 2));

    repeat (2) @(posedge clk);
    do_reset();
    foreach (tab0[i]) run_tab(0, tab0[i], i);

    do_reset();
    foreach (tab1[i]) run_tab(1, tab1[i], i);

    // Mid-burst async reset: build up state, then pull n_rst between edges.
    do_reset();
    run_tab(1, mk(1, 8'hC3, 2, 0, 0, 0, 4'h3, 1, 0, 1, 0, 4'b0100, 0), 100);
    run_tab(1, mk(1, 8'hE0, 2, 0, 0, 0, 4'h3, 0, 1, 0, 0, 4'b0100, 1), 101);
    store_pid = 1; p_out = 8'hE0;
    @(posedge clk);
    #2;
    n_rst = 0;
    #1;
    check("async_rst0", 0, obs(0), 20'h0);
    check("async_rst1", 0, obs(1), 20'h0);
    idle_inputs();
    @(negedge clk);
    n_rst = 1;
    @(posedge clk);
    #1;
    check("post_rst0", 0, obs(0), 20'h0);
    check("post_rst1", 0, obs(1), 20'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_pid_tracker.md
# rx_pid_tracker

Parametrised receive-side PID decoder and data-toggle tracker for the CDL receiver, used in place of the fixed 7-PID packet decoder. It captures the PID byte on `store_pid` and checks the PID's check nibble. It decodes the PID into the team's 4-bit packet code and checks DATA0/DATA1 sequencing against a per-endpoint expected-toggle table. It sits between the receive shift register (`p_out`) and the receiver control FSM, which consumes `rx_packet`, the single-cycle status pulses and the error counter.

## Interface
- NUM_EP, 4: number of tracked endpoints; 1..2^EP_W
- EP_W, 2: endpoint index width
- EXT_PIDS, 0: 0 = accept OUT/IN/DATA0/DATA1/ACK/NAK/STALL only; 1 = accept all 16 check-valid PIDs
- CNT_W, 8: error counter width

- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- store_pid  in  1  p_out holds a PID byte this cycle
- p_out  in  8  received byte, LSB = first bit on the wire
- ep_sel  in  EP_W  endpoint addressed by the current transaction
- clr_toggle  in  1  force expected toggle of clr_ep to 0
- clr_ep  in  EP_W  endpoint for clr_toggle
- clr_count  in  1  synchronous clear of err_count
- rx_packet  out  4  last accepted packet code, held; reset 4'b0000
- pid_valid  out  1  1-cycle pulse: PID accepted; reset 0
- pid_err  out  1  1-cycle pulse: PID rejected; reset 0
- data_ok  out  1  1-cycle pulse: DATA PID matched expected toggle; reset 0
- seq_err  out  1  1-cycle pulse: DATA PID toggle mismatch; reset 0
- exp_toggle  out  NUM_EP  expected toggle per endpoint (bit i = EP i); reset all 0
- err_count  out  CNT_W  saturating count of pid_err + seq_err; reset 0

## Operation
- The block evaluates only in cycles where store_pid=1. Otherwise all pulses are 0 and all state holds.
- Check rule: p_out[7:4] must equal ~p_out[3:0]. On failure: pid_err, rx_packet unchanged.
- Packet code = p_out[3:0]: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
- EXT_PIDS=0: any check-valid code outside that set → pid_err, rx_packet unchanged.
- EXT_PIDS=1: every check-valid code is accepted, including SETUP 1101, SOF 0101, DATA2 0111, MDATA 1111 and PRE/ERR 1100.
- On accept: rx_packet ← code and pid_valid=1.
- DATA0/DATA1 accepted with ep_sel < NUM_EP:
  - PID toggle bit (code[3]) equals exp_toggle[ep_sel] → data_ok, and exp_toggle[ep_sel] inverts.
  - Mismatch → seq_err, and exp_toggle is unchanged (retransmission case).
- DATA2/MDATA: no toggle check, no data_ok/seq_err.
- SETUP accepted (EXT_PIDS=1) with ep_sel < NUM_EP → exp_toggle[ep_sel] ← 0.
- ep_sel ≥ NUM_EP: the PID is still decoded and pid_valid still pulses, but the toggle table is untouched and data_ok/seq_err stay 0.
- clr_toggle with clr_ep < NUM_EP → exp_toggle[clr_ep] ← 0. With clr_ep ≥ NUM_EP, clr_toggle is ignored.
- err_count increments by 1 on each pid_err or seq_err and saturates at 2^CNT_W−1. The two pulses are mutually exclusive, so the step is never more than 1.
- clr_count zeroes err_count. If clr_count coincides with an error, the result is 0; clear wins.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- store_pid sampled at edge N → rx_packet, pulses, exp_toggle and err_count are updated after edge N. The pulses are high for exactly one cycle.
- Back-to-back store_pid cycles are each evaluated independently against the table state left by the previous cycle. Throughput is 1 PID/cycle.
- clr_toggle and a DATA update to the same endpoint in the same cycle:
  - data_ok/seq_err are computed from the pre-clear value.
  - The final exp_toggle bit is 0; clear wins.
- clr_toggle and a DATA update to different endpoints in the same cycle: both take effect.
- Asynchronous reset at any time, including mid-burst: all outputs return to their reset values immediately, and no pulse is emitted on the first edge after release unless store_pid=1 on that edge.

## Test plan
- Reset, then store_pid with p_out=8'hE1, 8'h69, 8'hD2 on consecutive cycles → rx_packet 0001, 1001, 0010, each with a pid_valid pulse; err_count stays 0.
- p_out=8'hE0 (bad check nibble) after an OUT → pid_err pulse, rx_packet stays 0001, err_count=1.
- EXT_PIDS=0, p_out=8'h2D (SETUP) → pid_err. With EXT_PIDS=1 the same byte → pid_valid, rx_packet=1101, and exp_toggle[ep_sel] is cleared.
- ep_sel=2, DATA0 (8'hC3) → data_ok, exp_toggle[2]=1. Then DATA0 again → seq_err, exp_toggle[2] stays 1. Then DATA1 (8'h4B) → data_ok, exp_toggle[2]=0.
- exp_toggle[1]=1; same cycle: clr_toggle with clr_ep=1, and DATA1 with ep_sel=1 → data_ok pulse, exp_toggle[1]=0.
- CNT_W=2, five bad PIDs → err_count 1,2,3,3,3. Then clr_count → 0. Assert n_rst mid-sequence → all outputs 0 asynchronously.
